mem_copy_engine: RTL
====================

Name: mem_copy_engine

Overview:
- Word-granular block-copy (memmove) initiator that drives the data-memory port (mem_addr / MemWrite / mem_write_data / mem_read_data) of the single-port word memory.
- The memory has combinational read, synchronous write on posedge, byte addresses and word index = addr>>2.
- Accepts a copy command and moves word_count 32-bit words from src_addr to dst_addr, one read cycle plus one write cycle per word.
- Copies backwards when the ranges overlap with dst above src, so the result is always memmove-correct.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the memory port.
- CNT_WIDTH, 16, width of word_count.
- MEM_WORDS, 8192, memory depth in words, used for the bounds check.

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  asynchronous active-low reset (0 = reset asserted)
- start  input  1  command strobe, sampled only in IDLE
- src_addr  input  ADDR_WIDTH  source byte address, latched on accepted start
- dst_addr  input  ADDR_WIDTH  destination byte address, latched on accepted start
- word_count  input  CNT_WIDTH  number of words, latched on accepted start
- busy  output  1  high in READ/WRITE states
- done  output  1  one-cycle pulse on successful completion (including count 0)
- error  output  1  one-cycle pulse on a rejected command
- mem_addr  output  ADDR_WIDTH  memory byte address
- MemWrite  output  1  memory write enable
- mem_write_data  output  32  memory write data
- mem_read_data  input  32  combinational memory read data

Behaviour:
- States: IDLE, READ, WRITE, FIN.
- Reset (asynchronous, rst=0): state IDLE; all internal registers 0; outputs busy=0, done=0, error=0, mem_addr=0, MemWrite=0, mem_write_data=0.
  - A reset mid-copy drops MemWrite immediately, with no further memory access.
  - Words already written stay written.
- IDLE: memory outputs all 0. On start=1 at edge T, latch the command, then:
  - Reject → FIN with error flag if src_addr[1:0]!=0, or dst_addr[1:0]!=0, or src_addr+4*word_count > 4*MEM_WORDS, or dst_addr+4*word_count > 4*MEM_WORDS.
    - Bounds arithmetic is carried at ADDR_WIDTH+CNT_WIDTH+2 bits, so there is no wrap.
  - word_count==0 and checks pass → FIN with no memory access.
  - Otherwise → READ. Direction is backward if dst_addr > src_addr and dst_addr < src_addr+4*word_count; else forward.
    - Forward: rd_ptr=src, wr_ptr=dst, step +4.
    - Backward: rd_ptr=src+4*(count-1), wr_ptr=dst+4*(count-1), step -4.
  - remaining = word_count.
- READ (busy=1): mem_addr=rd_ptr, MemWrite=0. At the edge, data_buf <= mem_read_data → WRITE.
- WRITE (busy=1): mem_addr=wr_ptr, MemWrite=1, mem_write_data=data_buf.
  - At the edge, memory commits the word; rd_ptr and wr_ptr step by ±4; remaining decrements.
  - Next state: FIN if remaining was 1, else READ.
- FIN (busy=0, memory outputs 0):
  - done=1 if success, error=1 if rejected (never both), for exactly one cycle.
  - Next state is IDLE.
- Latency: start accepted at edge T, so cycle T+1 is the first READ.
  - FIN (done) falls in cycle T+1+2N for N words; for N=0 or error, FIN is cycle T+1.
  - The next command can be accepted at the edge ending cycle T+2+2N.
- start is ignored in READ/WRITE/FIN. Input command ports are don't-care except at the accepting edge.
- src==dst is a legal copy: data is rewritten unchanged and the full cycle count is spent.
- word_count max (2^CNT_WIDTH-1) is legal if it is within bounds.
- Combinational outputs are decoded from the registered state and pointers only; there is no path from mem_read_data to any output.

Test Plan:
- Forward copy: mem[0x100..0x10C]=11,22,33,44; start src=0x100 dst=0x200 count=4 → words 0x200..0x20C = 11,22,33,44.
  - Expected cycles: done in cycle T+9, busy high cycles T+1..T+8, MemWrite high only in cycles T+2, T+4, T+6, T+8.
- Overlap backward: mem[0x00..0x0C]=1,2,3,4; src=0x00 dst=0x04 count=4 → mem[0x04..0x10]=1,2,3,4.
  - First READ addr 0x0C, first write addr 0x10.
- Overlap forward: same init, src=0x04 dst=0x00 count=3 → mem[0x00..0x08]=2,3,4.
- Zero/error: count=0 → done pulse at T+1 with no MemWrite.
  - src=0x102 → error pulse at T+1 with no access.
  - dst=0x7FFC count=2 (MEM_WORDS=8192) → error.
- start held high throughout a 2-word copy → exactly one copy performed; the second start is accepted only after FIN.
- rst driven low asynchronously mid-WRITE of word 2 of 4 → MemWrite=0 and busy=0 immediately.
  - Word 1 is copied, words 3-4 are untouched.
  - After release, a new command completes normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Word-granular memmove engine driving a single-port word memory.
// Copies backwards when the destination overlaps above the source.
module mem_copy_engine #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned MEM_WORDS  = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  MemWrite,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  localparam int unsigned ExtWidth = ADDR_WIDTH + CNT_WIDTH + 2;
  localparam logic [ExtWidth-1:0] Limit = ExtWidth'(64'(MEM_WORDS) * 64'd4);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StFin} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [31:0]           data_buf_q, data_buf_d;
  logic                  backward_q, backward_d;
  logic                  reject_q, reject_d;

  // Bounds are evaluated in a widened domain so no sum can wrap.
  logic [ExtWidth-1:0]   src_ext, dst_ext, len_ext, src_end, dst_end;
  logic [ADDR_WIDTH-1:0] last_off;
  logic                  cmd_reject, cmd_backward;

  assign src_ext  = ExtWidth'(src_addr);
  assign dst_ext  = ExtWidth'(dst_addr);
  assign len_ext  = ExtWidth'({word_count, 2'b00});
  assign src_end  = src_ext + len_ext;
  assign dst_end  = dst_ext + len_ext;
  assign last_off = ADDR_WIDTH'({word_count, 2'b00}) - ADDR_WIDTH'(4);

  assign cmd_reject = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00) ||
                      (src_end > Limit) || (dst_end > Limit);
  assign cmd_backward = (dst_ext > src_ext) && (dst_ext < src_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      data_buf_q  <= '0;
      backward_q  <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      data_buf_q  <= data_buf_d;
      backward_q  <= backward_d;
      reject_q    <= reject_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    data_buf_d  = data_buf_q;
    backward_d  = backward_q;
    reject_d    = reject_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          reject_d    = cmd_reject;
          backward_d  = cmd_backward;
          remaining_d = word_count;
          if (cmd_reject || (word_count == '0)) begin
            state_d = StFin;
          end else begin
            rd_ptr_d = cmd_backward ? src_addr + last_off : src_addr;
            wr_ptr_d = cmd_backward ? dst_addr + last_off : dst_addr;
            state_d  = StRead;
          end
        end
      end
      StRead: begin
        data_buf_d = mem_read_data;
        state_d    = StWrite;
      end
      StWrite: begin
        rd_ptr_d    = backward_q ? rd_ptr_q - ADDR_WIDTH'(4) : rd_ptr_q + ADDR_WIDTH'(4);
        wr_ptr_d    = backward_q ? wr_ptr_q - ADDR_WIDTH'(4) : wr_ptr_q + ADDR_WIDTH'(4);
        remaining_d = remaining_q - CNT_WIDTH'(1);
        state_d     = (remaining_q == CNT_WIDTH'(1)) ? StFin : StRead;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs depend only on registered state, so reset drops MemWrite at once.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    mem_addr       = '0;
    MemWrite       = 1'b0;
    mem_write_data = '0;
    unique case (state_q)
      StRead: begin
        busy     = 1'b1;
        mem_addr = rd_ptr_q;
      end
      StWrite: begin
        busy           = 1'b1;
        mem_addr       = wr_ptr_q;
        MemWrite       = 1'b1;
        mem_write_data = data_buf_q;
      end
      StFin: begin
        done  = !reject_q;
        error = reject_q;
      end
      default: ;
    endcase
  end

endmodule
